// File: rtl/vdp_host_port.sv
// CPU-side host port of the VDP: two-byte control decode, auto-incrementing VRAM
// address with read-ahead buffer, control registers, sticky status flags and irq.
// VRAM accesses are issued to the arbiter through a req/ack handshake.
module vdp_host_port #(
    parameter int unsigned VRAM_SIZE = 16384,
    parameter int unsigned NUM_REGS  = 8,
    localparam int unsigned ADDR_W   = $clog2(VRAM_SIZE),
    localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                    pxclk_i,
    input  logic                    reset_ni,
    input  logic                    wr_tick_i,
    input  logic                    rd_tick_i,
    input  logic                    mode_i,
    input  logic [7:0]              din_i,
    output logic [7:0]              dout_o,
    output logic [NUM_REGS*8-1:0]   regs_o,
    output logic                    vram_req_o,
    output logic                    vram_we_o,
    output logic [ADDR_W-1:0]       vram_addr_o,
    output logic [7:0]              vram_wdata_o,
    input  logic                    vram_ack_i,
    input  logic [7:0]              vram_rdata_i,
    input  logic                    frame_tick_i,
    input  logic                    fifth_tick_i,
    input  logic [4:0]              fifth_num_i,
    input  logic                    coll_tick_i,
    output logic                    overrun_o,
    output logic                    irq_o
);

    typedef enum logic [1:0] {StIdle, StWrReq, StRdReq} state_e;

    state_e                  state_q;
    logic                    req_q, we_q;
    logic [ADDR_W-1:0]       req_addr_q;
    logic [7:0]              req_wdata_q;

    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [7:0]              buf_q, buf_d;
    logic [7:0]              dout_q, dout_d;
    logic [NUM_REGS*8-1:0]   regs_q, regs_d;
    logic [7:0]              first_q, first_d;
    logic                    latch_q, latch_d;
    logic                    int_q, int_d;
    logic                    s5_q, s5_d;
    logic                    coll_q, coll_d;
    logic [4:0]              fifth_q, fifth_d;
    logic                    overrun_q, overrun_d;

    logic       ack_now, port_free;
    logic       data_wr, ctrl_wr, data_rd_ret, data_rd_acc, stat_rd;
    logic       ctrl_second, ctrl_reg, ctrl_addr_set, ctrl_prefetch;
    logic       want_wr, want_rd, issue_wr, issue_rd, dropped;
    logic [13:0] ctrl_addr;
    logic [7:0]  buf_eff;

    // Decode the CPU strobes into accesses and decide whether the VRAM port can take one.
    always_comb begin
        ack_now       = (state_q != StIdle) && vram_ack_i;
        // The ack cycle frees the port so a back-to-back access can start immediately.
        port_free     = (state_q == StIdle) || ack_now;
        data_wr       = wr_tick_i && !mode_i;
        ctrl_wr       = wr_tick_i && mode_i;
        data_rd_ret   = rd_tick_i && !mode_i;
        // A data read coinciding with a write returns the buffer but does not touch VRAM.
        data_rd_acc   = rd_tick_i && !mode_i && !wr_tick_i;
        stat_rd       = rd_tick_i && mode_i;
        ctrl_second   = ctrl_wr && latch_q;
        ctrl_reg      = ctrl_second && din_i[7];
        ctrl_addr_set = ctrl_second && !din_i[7];
        ctrl_prefetch = ctrl_addr_set && !din_i[6];
        ctrl_addr     = {din_i[5:0], first_q};
        want_wr       = data_wr;
        want_rd       = data_rd_acc || ctrl_prefetch;
        issue_wr      = want_wr && port_free;
        issue_rd      = want_rd && port_free;
        dropped       = (want_wr || want_rd) && !port_free;
        // Read data arriving this cycle is the freshest buffer content.
        buf_eff       = (ack_now && !we_q) ? vram_rdata_i : buf_q;
    end

    // Next-state for address, buffer, read data, registers and status flags.
    always_comb begin
        addr_d = addr_q;
        if (ack_now && we_q) begin
            addr_d = addr_q + 1'b1;
        end
        if (ctrl_addr_set) begin
            addr_d = ctrl_addr[ADDR_W-1:0];
        end
        if (data_rd_acc && port_free) begin
            addr_d = addr_d + 1'b1;
        end

        buf_d = buf_eff;
        if (issue_wr) begin
            buf_d = din_i;
        end

        dout_d = dout_q;
        if (data_rd_ret && (wr_tick_i || port_free)) begin
            dout_d = buf_eff;
        end
        if (stat_rd) begin
            dout_d = {int_q, s5_q, coll_q, fifth_q};
        end

        regs_d = regs_q;
        if (ctrl_reg) begin
            regs_d[{din_i[IDX_W-1:0], 3'b000} +: 8] = first_q;
        end

        first_d = first_q;
        latch_d = latch_q;
        if (stat_rd || data_wr || data_rd_ret) begin
            latch_d = 1'b0;
        end
        if (ctrl_wr) begin
            latch_d = !latch_q;
            if (!latch_q) begin
                first_d = din_i;
            end
        end

        // Set events win over the clear done by a status read in the same cycle.
        int_d     = frame_tick_i || (int_q && !stat_rd);
        s5_d      = fifth_tick_i || (s5_q && !stat_rd);
        coll_d    = coll_tick_i || (coll_q && !stat_rd);
        fifth_d   = fifth_tick_i ? fifth_num_i : fifth_q;
        overrun_d = dropped || (overrun_q && !stat_rd);
    end

    // Handshake FSM: hold request, direction, address and data until the arbiter acks.
    always_ff @(posedge pxclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else if (issue_wr || issue_rd) begin
            state_q     <= issue_wr ? StWrReq : StRdReq;
            req_q       <= 1'b1;
            we_q        <= issue_wr;
            req_addr_q  <= addr_d;
            req_wdata_q <= din_i;
        end else if (ack_now) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
        end
    end

    // Datapath state registers.
    always_ff @(posedge pxclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            addr_q    <= '0;
            buf_q     <= '0;
            dout_q    <= '0;
            regs_q    <= '0;
            first_q   <= '0;
            latch_q   <= 1'b0;
            int_q     <= 1'b0;
            s5_q      <= 1'b0;
            coll_q    <= 1'b0;
            fifth_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            buf_q     <= buf_d;
            dout_q    <= dout_d;
            regs_q    <= regs_d;
            first_q   <= first_d;
            latch_q   <= latch_d;
            int_q     <= int_d;
            s5_q      <= s5_d;
            coll_q    <= coll_d;
            fifth_q   <= fifth_d;
            overrun_q <= overrun_d;
        end
    end

    assign dout_o       = dout_q;
    assign regs_o       = regs_q;
    assign vram_req_o   = req_q;
    assign vram_we_o    = we_q;
    assign vram_addr_o  = req_addr_q;
    assign vram_wdata_o = req_wdata_q;
    assign overrun_o    = overrun_q;
    // Interrupt enable is bit 5 of register 1.
    assign irq_o        = int_q & regs_q[13];

endmodule

// File: tb/tb_vdp_host_port.sv
// Self-checking bench for vdp_host_port: a VRAM stub with variable ack latency,
// a transaction-level reference model, a control-write table, directed corner
// sequences and a randomized run.
module tb_vdp_host_port;

    localparam int unsigned VRAM = 16384;
    localparam int unsigned NREG = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr, rd, mode;
    logic [7:0]        din;
    logic [7:0]        dout;
    logic [NREG*8-1:0] regs;
    logic              req, we;
    logic [13:0]       vaddr;
    logic [7:0]        vwdata;
    logic              ack;
    logic [7:0]        rdata;
    logic              frame, fifth, coll;
    logic [4:0]        fnum;
    logic              ovr, irq;

    vdp_host_port #(.VRAM_SIZE(VRAM), .NUM_REGS(NREG)) dut (
        .pxclk_i      (clk),
        .reset_ni     (rst_n),
        .wr_tick_i    (wr),
        .rd_tick_i    (rd),
        .mode_i       (mode),
        .din_i        (din),
        .dout_o       (dout),
        .regs_o       (regs),
        .vram_req_o   (req),
        .vram_we_o    (we),
        .vram_addr_o  (vaddr),
        .vram_wdata_o (vwdata),
        .vram_ack_i   (ack),
        .vram_rdata_i (rdata),
        .frame_tick_i (frame),
        .fifth_tick_i (fifth),
        .fifth_num_i  (fnum),
        .coll_tick_i  (coll),
        .overrun_o    (ovr),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    // VRAM stub state
    logic [7:0] mem [VRAM];
    int  lat, wcnt, fixed_lat;
    bit  hold_ack, force_ack, rand_lat;

    // Reference model state
    logic [7:0] m_regs [NREG];
    int         m_addr;
    logic [7:0] m_buf, m_dout, m_first;
    bit         m_latch, m_int, m_5s, m_c, m_ovr;
    logic [4:0] m_fnum;
    bit         m_pend, m_pwe;
    int         m_paddr;
    logic [7:0] m_pdata;

    int n_vec, n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_addr = 0; m_buf = 0; m_dout = 0; m_first = 0;
        m_latch = 0; m_int = 0; m_5s = 0; m_c = 0; m_ovr = 0; m_fnum = 0;
        m_pend = 0; m_pwe = 0; m_paddr = 0; m_pdata = 0;
    endtask

    task automatic model_issue(input bit is_wr, input int a, input logic [7:0] d);
        m_pend = 1; m_pwe = is_wr; m_paddr = a; m_pdata = d;
    endtask

    // One clock of port behaviour from the current inputs, expressed as ordered rules.
    task automatic model_step();
        logic [7:0] st;
        bit         l0;
        st = {m_int, m_5s, m_c, m_fnum};
        l0 = m_latch;
        if (m_pend && ack) begin
            if (m_pwe) m_addr = (m_addr + 1) % VRAM;
            else       m_buf  = rdata;
            m_pend = 0;
        end
        if (rd && mode) begin
            m_dout = st;
            m_int = 0; m_5s = 0; m_c = 0; m_ovr = 0; m_latch = 0;
        end
        if (rd && !mode) begin
            m_latch = 0;
            if (wr) m_dout = m_buf;
            else if (!m_pend) begin
                m_dout = m_buf;
                m_addr = (m_addr + 1) % VRAM;
                model_issue(0, m_addr, din);
            end else m_ovr = 1;
        end
        if (wr && !mode) begin
            m_latch = 0;
            if (!m_pend) begin
                m_buf = din;
                model_issue(1, m_addr, din);
            end else m_ovr = 1;
        end
        if (wr && mode) begin
            if (!l0) begin
                m_first = din;
                m_latch = 1;
            end else begin
                m_latch = 0;
                if (din[7]) m_regs[din % NREG] = m_first;
                else begin
                    m_addr = {din[5:0], m_first} % VRAM;
                    if (!din[6]) begin
                        if (!m_pend) model_issue(0, m_addr, din);
                        else m_ovr = 1;
                    end
                end
            end
        end
        if (frame) m_int = 1;
        if (fifth) begin m_5s = 1; m_fnum = fnum; end
        if (coll) m_c = 1;
    endtask

    task automatic check_model();
        chk("dout", dout, m_dout);
        chk("vram_req", req, m_pend);
        chk("overrun", ovr, m_ovr);
        chk("irq", irq, m_int & m_regs[1][5]);
        for (int i = 0; i < NREG; i++) chk("regs", regs[i*8 +: 8], m_regs[i]);
        if (m_pend) begin
            chk("vram_we", we, m_pwe);
            chk("vram_addr", vaddr, m_paddr);
            if (m_pwe) chk("vram_wdata", vwdata, m_pdata);
        end
    endtask

    // Drive the VRAM stub, advance the model, clock once and compare.
    task automatic step();
        ack = 0;
        rdata = 8'h00;
        if (force_ack) ack = 1;
        else if (req && !hold_ack) begin
            if (wcnt >= lat) begin
                ack = 1;
                rdata = mem[vaddr];
                if (we) mem[vaddr] = vwdata;
                wcnt = 0;
                lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
            end else wcnt++;
        end
        model_step();
        @(posedge clk);
        #1;
        check_model();
        wr = 0; rd = 0; frame = 0; fifth = 0; coll = 0; force_ack = 0; ack = 0;
    endtask

    task automatic ctrl_w(input logic [7:0] b);
        mode = 1; wr = 1; din = b; step();
    endtask
    task automatic data_w(input logic [7:0] b);
        mode = 0; wr = 1; din = b; step();
    endtask
    task automatic data_r();
        mode = 0; rd = 1; step();
    endtask
    task automatic stat_r();
        mode = 1; rd = 1; step();
    endtask
    task automatic wait_idle();
        int k;
        k = 0;
        while (req && k < 50) begin step(); k++; end
        chk("wait_idle_timeout", req, 1'b0);
    endtask

    typedef struct {
        bit         mode;
        bit         wr;
        bit         rd;
        logic [7:0] din;
        int         chk_reg;
        logic [7:0] exp_reg;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0;
        wr = 0; rd = 0; mode = 0; din = 0; ack = 0; rdata = 0;
        frame = 0; fifth = 0; fnum = 0; coll = 0;
        hold_ack = 0; force_ack = 0; rand_lat = 0; fixed_lat = 0; lat = 0; wcnt = 0;
        for (int i = 0; i < VRAM; i++) mem[i] = 8'h00;
        model_reset();
        rst_n = 0;
        #1;
        chk("reset_dout", dout, 8'h00);
        chk("reset_regs", regs, 64'h0);
        chk("reset_req", req, 1'b0);
        chk("reset_overrun", ovr, 1'b0);
        chk("reset_irq", irq, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Control-register writes, including index wrap
        tbl[0] = '{1, 1, 0, 8'h34, -1, 8'h00};
        tbl[1] = '{1, 1, 0, 8'h87,  7, 8'h34};
        tbl[2] = '{1, 1, 0, 8'h12, -1, 8'h00};
        tbl[3] = '{1, 1, 0, 8'h8F,  7, 8'h12};
        tbl[4] = '{1, 1, 0, 8'h20, -1, 8'h00};
        tbl[5] = '{1, 1, 0, 8'h81,  1, 8'h20};
        tbl[6] = '{1, 1, 0, 8'h5A, -1, 8'h00};
        tbl[7] = '{1, 0, 1, 8'h00, -1, 8'h00};
        tbl[8] = '{1, 1, 0, 8'hC3, -1, 8'h00};
        tbl[9] = '{1, 1, 0, 8'h82,  2, 8'hC3};
        for (int i = 0; i < 10; i++) begin
            mode = tbl[i].mode; wr = tbl[i].wr; rd = tbl[i].rd; din = tbl[i].din;
            step();
            if (tbl[i].chk_reg >= 0)
                chk("tbl_reg", regs[tbl[i].chk_reg*8 +: 8], tbl[i].exp_reg);
        end

        // Sequential data writes with slow ack
        fixed_lat = 3; lat = 3;
        ctrl_w(8'h00); ctrl_w(8'h40);
        data_w(8'hAA); wait_idle();
        data_w(8'hBB); wait_idle();
        chk("vram0", mem[0], 8'hAA);
        chk("vram1", mem[1], 8'hBB);
        data_w(8'hCC);
        chk("addr_after_two", vaddr, 14'd2);
        wait_idle();

        // Address wrap at top of VRAM
        ctrl_w(8'hFF); ctrl_w(8'h7F);
        data_w(8'h55);
        chk("wr_top_addr", vaddr, 14'h3FFF);
        wait_idle();
        chk("vram_top", mem[16'h3FFF], 8'h55);
        data_w(8'h66);
        chk("wrap_addr", vaddr, 14'h0000);
        wait_idle();

        // Prefetch then two data reads
        mem[16'h10] = 8'h11; mem[16'h11] = 8'h22;
        ctrl_w(8'h10); ctrl_w(8'h00);
        wait_idle();
        data_r();
        chk("read1", dout, 8'h11);
        wait_idle();
        data_r();
        chk("read2", dout, 8'h22);
        wait_idle();

        // Frame interrupt and status clear, with set winning over clear
        frame = 1; step();
        chk("irq_set", irq, 1'b1);
        stat_r();
        chk("status_int", dout[7], 1'b1);
        chk("irq_cleared", irq, 1'b0);
        frame = 1; step();
        frame = 1; stat_r();
        chk("irq_set_wins", irq, 1'b1);
        stat_r();
        chk("status_int2", dout[7], 1'b1);

        // Overrun with ack held, then reset mid-request
        hold_ack = 1;
        data_w(8'h01);
        data_w(8'h02);
        chk("overrun_set", ovr, 1'b1);
        chk("first_kept", vwdata, 8'h01);
        #2 rst_n = 0;
        #1;
        chk("rst_req", req, 1'b0);
        chk("rst_overrun", ovr, 1'b0);
        model_reset();
        wcnt = 0; hold_ack = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        force_ack = 1; step();
        chk("stale_ack_ignored", req, 1'b0);

        // Randomized traffic against the model
        rand_lat = 1; lat = 0; wcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            din = 8'($urandom);
            if (r < 15) begin mode = 0; wr = 1; end
            else if (r < 30) begin mode = 0; rd = 1; end
            else if (r < 42) begin mode = 1; wr = 1; end
            else if (r < 47) begin mode = 1; rd = 1; end
            else if (r < 50) begin mode = 1'($urandom); wr = 1; rd = 1; end
            frame = ($urandom_range(0, 19) == 0);
            fifth = ($urandom_range(0, 19) == 0);
            coll  = ($urandom_range(0, 19) == 0);
            fnum  = 5'($urandom);
            hold_ack = ($urandom_range(0, 9) == 0);
            step();
        end
        hold_ack = 0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
